mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the IF stage (fetch requester) and the MEM stage (load/store requester) of the 5-stage pipeline.
- Sequences each memory transaction through a small FSM and returns read data to the winning requester.
- Drives per-stage stall requests that the hazard unit ORs into stall_f / stall_d and the MEM-stage hold.
- Fixed priority: data access (older instruction) over fetch. A branch flush (pcsrc_e) discards an in-flight fetch. A timeout counter guards against a hung memory.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
MAX_WAIT, 15, maximum cycles in a wait state without mem_ready before a timeout is forced (range 1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_valid
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, valid when if_valid=1
if_valid  out  1  one-cycle pulse, fetch complete
dm_req  in  1  data request, held until dm_valid
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_be  in  4  store byte enables
dm_rdata  out  DATA_W  load data, valid when dm_valid=1
dm_valid  out  1  one-cycle pulse, data access complete
pcsrc_e  in  1  branch/jump taken in EX; kills pending or in-flight fetch
stall_if  out  1  if_req & ~if_valid
stall_mem  out  1  dm_req & ~dm_valid
mem_req  out  1  memory request, high throughout I_WAIT/D_WAIT
mem_we  out  1  registered write enable
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered store data
mem_be  out  4  registered byte enables (4'hF for fetches and loads)
mem_ready  in  1  memory completes the transaction this cycle
mem_rdata  in  DATA_W  read data, sampled when mem_req & mem_ready
bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE, wait counter 0, drop flag 0. All registered outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, if_valid, dm_rdata, dm_valid, bus_err. mem_req falls immediately, even mid-transaction. Any aborted transaction is lost and is not replayed.
- Request masking: in a cycle where x_valid=1, x_req is ignored for arbitration. Requesters drop or change req in that cycle.
- States:
  - IDLE:
    - If dm_req (unmasked): capture dm_we, dm_addr, dm_wdata, dm_be into the mem_* registers, then go to D_WAIT.
    - Else if if_req (unmasked) and pcsrc_e=0: capture if_addr with mem_we=0 and mem_be=4'hF, then go to I_WAIT.
    - Otherwise stay in IDLE.
  - I_WAIT / D_WAIT:
    - mem_req=1. The counter increments each cycle that mem_ready=0.
    - On mem_req & mem_ready: latch mem_rdata into if_rdata (I_WAIT) or dm_rdata (D_WAIT load only; a store leaves dm_rdata unchanged). Pulse the matching valid in the next cycle, clear the counter, go to IDLE.
- Latency: a request sampled in IDLE in cycle N gives mem_req=1 in cycle N+1. If mem_ready=1 in cycle N+1, valid=1 in cycle N+2. Minimum 2 cycles. There is one IDLE cycle between back-to-back transactions.
- Flush:
  - pcsrc_e=1 in IDLE blocks a fetch grant that cycle; a data grant is unaffected.
  - pcsrc_e=1 in any I_WAIT cycle sets the drop flag. The transaction still completes on the memory side, but if_valid stays 0 and if_rdata is not updated. The drop flag clears on the return to IDLE.
  - pcsrc_e has no effect in D_WAIT.
- Timeout: when the counter reaches MAX_WAIT with mem_ready still 0:
  - mem_req deasserts;
  - bus_err pulses for one cycle;
  - the matching valid pulses (if not dropped) with rdata = 0;
  - state returns to IDLE.
- Simultaneous dm_req and if_req in IDLE: data wins. The fetch is served on the next IDLE unless flushed. stall_if stays high throughout.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Reset, then if_req=1 with if_addr=0x100 and mem_ready tied 1 -> mem_req/mem_addr=0x100 in cycle 1; if_valid=1 with if_rdata=mem_rdata in cycle 2; stall_if=1 in cycles 0-1 and 0 in cycle 2.
- if_req and dm_req both 1 in the same cycle (dm load at 0x2000) -> data serviced first (dm_valid), one IDLE cycle, then fetch serviced; stall_if high until if_valid.
- Store with dm_be=4'b0011, dm_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_be=0011 and mem_wdata=0xDEADBEEF held stable for all 4 wait cycles; dm_valid pulses once; dm_rdata unchanged.
- Fetch in flight, pcsrc_e=1 for one cycle during I_WAIT -> mem transaction completes, if_valid never pulses, if_rdata unchanged; the next fetch to the new address proceeds normally.
- mem_ready held 0 with MAX_WAIT=15 -> bus_err pulses exactly once after 15 wait cycles, valid pulses with rdata=0, FSM back to IDLE.
- rst_n asserted low mid-D_WAIT -> mem_req drops asynchronously, all outputs 0; after release, a new request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM requesters, the shared memory and the port arbiter.
// slave is the arbiter side; master is the pipeline/memory side that drives requests and ready.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   // Fetch requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;

   // Load/store requester
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [3:0]        dm_be;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;

   // Pipeline control
   logic              pcsrc_e;
   logic              stall_if;
   logic              stall_mem;

   // Memory side
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_be;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              bus_err;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, pcsrc_e,
             mem_ready, mem_rdata,
      output if_rdata, if_valid, dm_rdata, dm_valid, stall_if, stall_mem,
             mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_err
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, pcsrc_e,
             mem_ready, mem_rdata,
      input  if_rdata, if_valid, dm_rdata, dm_valid, stall_if, stall_mem,
             mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between fetch (IF) and load/store (MEM).
// Data beats fetch; a taken branch kills a pending/in-flight fetch; a wait timeout raises bus_err.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 15
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIWait = 2'd1,
      StDWait = 2'd2
   } state_e;

   // Counter value on the last not-ready cycle that is still tolerated.
   localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

   state_e            state_q,     state_d;
   logic [7:0]        wait_cnt_q,  wait_cnt_d;
   logic              drop_q,      drop_d;
   logic              mem_req_q,   mem_req_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_be_q,    mem_be_d;
   logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
   logic              if_valid_q,  if_valid_d;
   logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
   logic              dm_valid_q,  dm_valid_d;
   logic              bus_err_q,   bus_err_d;

   logic              dm_grant;
   logic              if_grant;
   logic              drop_now;
   logic              done;
   logic              timeout;
   logic [DATA_W-1:0] rdata_sel;

   // A requester whose valid pulses this cycle is ignored until it re-presents next cycle.
   assign dm_grant = bus.dm_req & ~dm_valid_q;
   assign if_grant = bus.if_req & ~if_valid_q & ~bus.pcsrc_e;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         wait_cnt_q  <= 8'd0;
         drop_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= 4'h0;
         if_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_rdata_q  <= '0;
         dm_valid_q  <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         drop_q      <= drop_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         if_rdata_q  <= if_rdata_d;
         if_valid_q  <= if_valid_d;
         dm_rdata_q  <= dm_rdata_d;
         dm_valid_q  <= dm_valid_d;
         bus_err_q   <= bus_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      drop_d      = drop_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      if_rdata_d  = if_rdata_q;
      if_valid_d  = 1'b0;
      dm_rdata_d  = dm_rdata_q;
      dm_valid_d  = 1'b0;
      bus_err_d   = 1'b0;
      drop_now    = 1'b0;
      done        = 1'b0;
      timeout     = 1'b0;
      rdata_sel   = '0;

      case (state_q)
         StIdle: begin
            wait_cnt_d = 8'd0;
            drop_d     = 1'b0;
            if (dm_grant) begin
               state_d     = StDWait;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.dm_we;
               mem_addr_d  = bus.dm_addr;
               mem_wdata_d = bus.dm_wdata;
               mem_be_d    = bus.dm_we ? bus.dm_be : 4'hF;
            end else if (if_grant) begin
               state_d    = StIWait;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = bus.if_addr;
               mem_be_d   = 4'hF;
            end
         end

         StIWait, StDWait: begin
            // A flush in the completing cycle still suppresses the fetch result.
            drop_now = drop_q | ((state_q == StIWait) & bus.pcsrc_e);
            drop_d   = drop_now;
            if (bus.mem_ready) begin
               done      = 1'b1;
               rdata_sel = bus.mem_rdata;
            end else if (wait_cnt_q == WaitLast) begin
               done      = 1'b1;
               timeout   = 1'b1;
               bus_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end

            if (done) begin
               state_d    = StIdle;
               mem_req_d  = 1'b0;
               wait_cnt_d = 8'd0;
               drop_d     = 1'b0;
               if (state_q == StIWait) begin
                  if (!drop_now) begin
                     if_valid_d = 1'b1;
                     if_rdata_d = rdata_sel;
                  end
               end else begin
                  dm_valid_d = 1'b1;
                  if (!mem_we_q || timeout) begin
                     dm_rdata_d = rdata_sel;
                  end
               end
            end
         end

         default: begin
            state_d   = StIdle;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      bus.mem_req   = mem_req_q;
      bus.mem_we    = mem_we_q;
      bus.mem_addr  = mem_addr_q;
      bus.mem_wdata = mem_wdata_q;
      bus.mem_be    = mem_be_q;
      bus.if_rdata  = if_rdata_q;
      bus.if_valid  = if_valid_q;
      bus.dm_rdata  = dm_rdata_q;
      bus.dm_valid  = dm_valid_q;
      bus.bus_err   = bus_err_q;
      bus.stall_if  = bus.if_req & ~if_valid_q;
      bus.stall_mem = bus.dm_req & ~dm_valid_q;
   end

endmodule
